// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: master side of the LSU-to-data-SRAM interface.
// Takes one load/store from EXU, issues a single-cycle SRAM request, waits
// for the SRAM response (or a timeout), extracts/extends load data and holds
// the result for WBU until it is accepted. All outputs are registered: the
// combinational block computes the value each output takes in the next state.
module lsu_mem_initiator #(
  parameter int DATA_W  = 32,
  parameter int OPT_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [OPT_W-1:0]  i_opt,
  output logic              o_mem_valid,
  output logic [DATA_W-1:0] o_mem_raddr,
  output logic              o_mem_ren,
  output logic [DATA_W-1:0] o_mem_waddr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wen,
  output logic [OPT_W-1:0]  o_mem_store_opt,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Last WAIT cycle: counter starts at 0, so TIMEOUT cycles end at TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [OPT_W-1:0] OP_LB  = OPT_W'(1);
  localparam logic [OPT_W-1:0] OP_LH  = OPT_W'(2);
  localparam logic [OPT_W-1:0] OP_LW  = OPT_W'(3);
  localparam logic [OPT_W-1:0] OP_LBU = OPT_W'(4);
  localparam logic [OPT_W-1:0] OP_LHU = OPT_W'(5);
  localparam logic [OPT_W-1:0] OP_SB  = OPT_W'(9);
  localparam logic [OPT_W-1:0] OP_SH  = OPT_W'(10);
  localparam logic [OPT_W-1:0] OP_SW  = OPT_W'(11);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic op_is_load(input logic [OPT_W-1:0] op);
    logic res;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_is_store(input logic [OPT_W-1:0] op);
    logic res;
    case (op)
      OP_SB, OP_SH, OP_SW: res = 1'b1;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic op_misaligned(input logic [OPT_W-1:0] op,
                                         input logic [1:0]       lane);
    logic res;
    case (op)
      OP_LH, OP_LHU, OP_SH: res = lane[0];
      OP_LW, OP_SW:         res = (lane != 2'b00);
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

  // Select the addressed byte/halfword lane and sign- or zero-extend it.
  function automatic logic [DATA_W-1:0] load_extract(input logic [OPT_W-1:0]  op,
                                                     input logic [1:0]        lane,
                                                     input logic [DATA_W-1:0] rdata);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] res;
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[1], 4'b0000} +: 16];
    case (op)
      OP_LB:   res = {{(DATA_W-8){b[7]}}, b};
      OP_LBU:  res = {{(DATA_W-8){1'b0}}, b};
      OP_LH:   res = {{(DATA_W-16){h[15]}}, h};
      OP_LHU:  res = {{(DATA_W-16){1'b0}}, h};
      OP_LW:   res = rdata;
      default: res = {DATA_W{1'b0}};
    endcase
    return res;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [OPT_W-1:0]   opt_r, opt_s;
  logic [1:0]         lane_r, lane_s;

  logic               ready_s, mem_valid_s, ren_s, wen_s, wb_valid_s, err_s;
  logic [DATA_W-1:0]  raddr_s, waddr_s, wdata_s, wb_data_s;
  logic [OPT_W-1:0]   store_opt_s;
  logic               req_legal_s;

  // Next-state and next-output computation for the request/response FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    opt_s       = opt_r;
    lane_s      = lane_r;
    ready_s     = 1'b0;
    mem_valid_s = 1'b0;
    ren_s       = 1'b0;
    wen_s       = 1'b0;
    raddr_s     = {DATA_W{1'b0}};
    waddr_s     = {DATA_W{1'b0}};
    wdata_s     = {DATA_W{1'b0}};
    store_opt_s = {OPT_W{1'b0}};
    wb_valid_s  = 1'b0;
    wb_data_s   = {DATA_W{1'b0}};
    err_s       = 1'b0;
    req_legal_s = (op_is_load(i_opt) || op_is_store(i_opt)) &&
                  !op_misaligned(i_opt, i_addr[1:0]);
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          opt_s  = i_opt;
          lane_s = i_addr[1:0];
          if (req_legal_s) begin
            state_s     = ST_REQ;
            mem_valid_s = 1'b1;
            if (op_is_load(i_opt)) begin
              ren_s   = 1'b1;
              raddr_s = {i_addr[DATA_W-1:2], 2'b00};
            end else begin
              wen_s       = 1'b1;
              waddr_s     = i_addr;
              wdata_s     = i_wdata;
              store_opt_s = i_opt;
            end
          end else begin
            // Illegal or misaligned: answer with an error, no SRAM access.
            state_s    = ST_RESP;
            wb_valid_s = 1'b1;
            err_s      = 1'b1;
          end
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_REQ: begin
        state_s     = ST_WAIT;
        cnt_s       = {CNT_W{1'b0}};
        store_opt_s = o_mem_store_opt;
      end
      ST_WAIT: begin
        cnt_s = cnt_r + CNT_W'(1);
        if (i_mem_valid) begin
          state_s    = ST_RESP;
          wb_valid_s = 1'b1;
          if (op_is_load(opt_r)) begin
            wb_data_s = load_extract(opt_r, lane_r, i_mem_rdata);
          end else begin
            wb_data_s = {DATA_W{1'b0}};
          end
        end else if (cnt_r == CNT_LAST) begin
          state_s    = ST_RESP;
          wb_valid_s = 1'b1;
          err_s      = 1'b1;
        end else begin
          store_opt_s = o_mem_store_opt;
        end
      end
      ST_RESP: begin
        if (i_wb_ready) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
        end else begin
          wb_valid_s = 1'b1;
          wb_data_s  = o_wb_data;
          err_s      = o_err;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
      end
    endcase
  end

  // State, captured operation and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      cnt_r           <= {CNT_W{1'b0}};
      opt_r           <= {OPT_W{1'b0}};
      lane_r          <= 2'b00;
      o_ready         <= 1'b1;
      o_mem_valid     <= 1'b0;
      o_mem_ren       <= 1'b0;
      o_mem_wen       <= 1'b0;
      o_mem_raddr     <= {DATA_W{1'b0}};
      o_mem_waddr     <= {DATA_W{1'b0}};
      o_mem_wdata     <= {DATA_W{1'b0}};
      o_mem_store_opt <= {OPT_W{1'b0}};
      o_wb_valid      <= 1'b0;
      o_wb_data       <= {DATA_W{1'b0}};
      o_err           <= 1'b0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      opt_r           <= opt_s;
      lane_r          <= lane_s;
      o_ready         <= ready_s;
      o_mem_valid     <= mem_valid_s;
      o_mem_ren       <= ren_s;
      o_mem_wen       <= wen_s;
      o_mem_raddr     <= raddr_s;
      o_mem_waddr     <= waddr_s;
      o_mem_wdata     <= wdata_s;
      o_mem_store_opt <= store_opt_s;
      o_wb_valid      <= wb_valid_s;
      o_wb_data       <= wb_data_s;
      o_err           <= err_s;
    end
  end

endmodule
